// File: rtl/result_tx.sv
`default_nettype none
// ============================================================================
// Module   : result_tx
// Purpose  : Framed, idle-high, MSB-first serial sender for 730/850 nm result
//            pairs, with a one-entry pending buffer for a pair that arrives
//            mid-frame. Optional even-parity bit: define RESULT_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module result_tx #(
    parameter int ADC_DATLEN   = 12,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADC_DATLEN-1:0] max730,
    input  logic [ADC_DATLEN-1:0] max850,
    output logic                  tx,
    output logic                  busy,
    output logic                  ready,
    output logic                  done,
    output logic                  drop
);

    localparam int c_DATA_W = 2 * ADC_DATLEN;
    localparam int c_BIT_W  = (c_DATA_W > 1) ? $clog2(c_DATA_W) : 1;
    localparam int c_DIV_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef RESULT_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]          r_state;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_BIT_W-1:0]  r_bit;
    logic [c_DATA_W-1:0] r_shift;
    logic                r_pend_valid;
    logic [c_DATA_W-1:0] r_pend_data;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;
    logic                r_drop;

    logic [2:0]          w_state_nxt;
    logic [c_DIV_W-1:0]  w_div_nxt;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic [c_DATA_W-1:0] w_shift_nxt;
    logic                w_pend_valid_nxt;
    logic [c_DATA_W-1:0] w_pend_data_nxt;
    logic                w_drop_nxt;
    logic                w_launch;
    logic [c_DATA_W-1:0] w_launch_data;
    logic [c_DATA_W-1:0] w_load_data;
    logic                w_bit_end;
    logic                w_frame_end;
    logic                w_tx_nxt;
    logic                w_done_nxt;

    assign w_load_data = {max730, max850};
    assign w_bit_end   = (r_div == c_DIV_LAST);
    assign w_frame_end = (r_state == c_ST_STOP) && w_bit_end;

`ifdef RESULT_TX_PARITY_EN
    logic r_parity;
    logic w_parity_nxt;

    // Parity is fixed per frame, so it is taken from the word being launched.
    assign w_parity_nxt = w_launch ? (^w_launch_data) : r_parity;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_div_nxt        = r_div + c_DIV_ONE;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_drop_nxt       = 1'b0;
        w_launch         = 1'b0;
        w_launch_data    = w_load_data;

        case (r_state)
            c_ST_IDLE: begin
                w_div_nxt = '0;
                w_launch  = load;
            end
            c_ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = c_ST_DATA;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_div_nxt = '0;
                    if (r_bit == c_BIT_LAST) begin
`ifdef RESULT_TX_PARITY_EN
                        w_state_nxt = c_ST_PARITY;
`else
                        w_state_nxt = c_ST_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + c_BIT_ONE;
                        w_shift_nxt = {r_shift[c_DATA_W-2:0], 1'b0};
                    end
                end
            end
`ifdef RESULT_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = c_ST_STOP;
                    w_div_nxt   = '0;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_bit_end) begin
                    // A pending pair always goes first; a coincident load refills the slot.
                    if (r_pend_valid) begin
                        w_launch         = 1'b1;
                        w_launch_data    = r_pend_data;
                        w_pend_valid_nxt = load;
                        if (load) begin
                            w_pend_data_nxt = w_load_data;
                        end
                    end else if (load) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_div_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_div_nxt   = '0;
            end
        endcase

        if (load && (r_state != c_ST_IDLE) && !w_frame_end) begin
            if (r_pend_valid) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_pend_valid_nxt = 1'b1;
                w_pend_data_nxt  = w_load_data;
            end
        end

        if (w_launch) begin
            w_state_nxt = c_ST_START;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
            w_shift_nxt = w_launch_data;
        end
    end

    // Line level is derived from the next state so that tx is a flop output.
    always_comb begin
        case (w_state_nxt)
            c_ST_START:  w_tx_nxt = 1'b0;
            c_ST_DATA:   w_tx_nxt = w_shift_nxt[c_DATA_W-1];
`ifdef RESULT_TX_PARITY_EN
            c_ST_PARITY: w_tx_nxt = w_parity_nxt;
`endif
            default:     w_tx_nxt = 1'b1;
        endcase
    end

    assign w_done_nxt = (w_state_nxt == c_ST_STOP) && (w_div_nxt == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_done       <= w_done_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

`ifdef RESULT_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign tx    = r_tx;
    assign busy  = r_busy;
    assign ready = ~r_pend_valid;
    assign done  = r_done;
    assign drop  = r_drop;

endmodule
`default_nettype wire
